c2f_chunk_arbiter: RTL and testbench

C2F_CHUNK_ARBITER -- requirements
Module: c2f_chunk_arbiter

---
 rtl/c2f_chunk_arbiter.sv | 107 ++++++++++
 tb/tb_c2f_chunk_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c2f_chunk_arbiter.sv
// Two-requester round-robin arbiter handing out chunks of a circular chunk buffer.
// Define C2F_ARB_TIMEOUT_EN to add an owner watchdog and the timeout_out pulse.
module c2f_chunk_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int INDEX_W        = 4,
  parameter int OFFSET_W       = 10
) (
  input  logic                sysClk_in,
  input  logic                sysRst_in,
  input  logic [INDEX_W-1:0]  wrIndex_in,
  output logic [INDEX_W-1:0]  rdIndex_out,
  input  logic                req0_in,
  input  logic                req1_in,
  input  logic                ack0_in,
  input  logic                ack1_in,
  input  logic [OFFSET_W-1:0] rdOffset0_in,
  input  logic [OFFSET_W-1:0] rdOffset1_in,
  output logic                grant0_out,
  output logic                grant1_out,
  output logic [OFFSET_W-1:0] rdOffset_out,
  output logic                avail_out,
`ifdef C2F_ARB_TIMEOUT_EN
  output logic                timeout_out,
`endif
  output logic [1:0]          dbg_state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT0  = 2'd1;
  localparam logic [1:0] S_GRANT1  = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  // Handshake: reqN_in is a level; the grant is a registered level that stays up
  // until a one-cycle ackN_in pulse from the owner (or a watchdog expiry).
  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       rr_ptr;
  logic       release_now;
  logic       ack_owner;
  logic       timeout_hit;

  assign avail_out    = (wrIndex_in != rdIndex_out);
  assign grant0_out   = (state == S_GRANT0);
  assign grant1_out   = (state == S_GRANT1);
  assign rdOffset_out = (state == S_GRANT1) ? rdOffset1_in : rdOffset0_in;
  assign dbg_state    = state;
  assign ack_owner    = ((state == S_GRANT0) && ack0_in) || ((state == S_GRANT1) && ack1_in);

  always_comb begin
    state_nxt   = state;
    release_now = 1'b0;
    case (state)
      S_IDLE: begin
        if (avail_out && (req0_in || req1_in)) begin
          if (req0_in && req1_in) state_nxt = rr_ptr ? S_GRANT1 : S_GRANT0;
          else                    state_nxt = req0_in ? S_GRANT0 : S_GRANT1;
        end
      end
      S_GRANT0, S_GRANT1: begin
        if (ack_owner || timeout_hit) begin
          state_nxt   = S_RELEASE;
          release_now = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sysClk_in or posedge sysRst_in) begin
    if (sysRst_in) begin
      state       <= S_IDLE;
      rdIndex_out <= '0;
      rr_ptr      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (release_now) begin
        rdIndex_out <= rdIndex_out + 1'b1;
        // Favour the requester that did not just own the chunk.
        rr_ptr      <= (state == S_GRANT0);
      end
    end
  end

`ifdef C2F_ARB_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

  logic            in_grant;
  logic [WD_W-1:0] wd;

  assign in_grant    = (state == S_GRANT0) || (state == S_GRANT1);
  assign timeout_hit = in_grant && (wd == WD_LIMIT);

  always_ff @(posedge sysClk_in or posedge sysRst_in) begin
    if (sysRst_in) begin
      wd          <= '0;
      timeout_out <= 1'b0;
    end else begin
      wd          <= (in_grant && !release_now) ? wd + 1'b1 : '0;
      timeout_out <= timeout_hit && !ack_owner;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_c2f_chunk_arbiter.sv
// Directed bench for c2f_chunk_arbiter; the watchdog scenario runs when
// C2F_ARB_TIMEOUT_EN is defined.
module tb_c2f_chunk_arbiter;

  localparam int IW = 4;
  localparam int OW = 10;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT0  = 2'd1;
  localparam logic [1:0] S_GRANT1  = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [IW-1:0] wr_index = '0;
  logic [IW-1:0] rd_index;
  logic          req0 = 1'b0, req1 = 1'b0, ack0 = 1'b0, ack1 = 1'b0;
  logic [OW-1:0] off0 = '0, off1 = '0;
  logic          grant0, grant1, avail;
  logic [OW-1:0] off_mux;
  logic [1:0]    state;
`ifdef C2F_ARB_TIMEOUT_EN
  logic          timeout;
`endif

  int errors = 0;
  int checks = 0;

  c2f_chunk_arbiter #(.TIMEOUT_CYCLES(16), .INDEX_W(IW), .OFFSET_W(OW)) dut (
    .sysClk_in   (clk),
    .sysRst_in   (rst),
    .wrIndex_in  (wr_index),
    .rdIndex_out (rd_index),
    .req0_in     (req0),
    .req1_in     (req1),
    .ack0_in     (ack0),
    .ack1_in     (ack1),
    .rdOffset0_in(off0),
    .rdOffset1_in(off1),
    .grant0_out  (grant0),
    .grant1_out  (grant1),
    .rdOffset_out(off_mux),
    .avail_out   (avail),
`ifdef C2F_ARB_TIMEOUT_EN
    .timeout_out (timeout),
`endif
    .dbg_state   (state)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0 = 0; req1 = 0; ack0 = 0; ack1 = 0; wr_index = '0; off0 = '0; off1 = '0;
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic pulse_ack(input bit which);
    if (which) ack1 = 1; else ack0 = 1;
    tick();
    ack0 = 0; ack1 = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    #1;
    checks++;
    if ({state, grant0, grant1, rd_index, avail} !== {S_IDLE, 1'b0, 1'b0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got st=%0d g0=%0b g1=%0b rd=%0d av=%0b, expected st=0 g=00 rd=0 av=0",
               state, grant0, grant1, rd_index, avail);
    end
    tick();
    rst = 0;
  endtask

  task automatic test_single_grant();
    do_reset();
    wr_index = 4'd1;
    req0 = 1;
    #1;
    checks++;
    if ({grant0, avail} !== 2'b01) begin
      errors++; $display("FAIL single_pre_edge: got g0=%0b av=%0b, expected g0=0 av=1", grant0, avail);
    end
    tick();
    checks++;
    if ({grant0, grant1} !== 2'b10) begin
      errors++; $display("FAIL single_grant: got g0=%0b g1=%0b, expected 1 0", grant0, grant1);
    end
    req0 = 0;
    pulse_ack(0);
    checks++;
    if ({state, grant0, rd_index, avail} !== {S_RELEASE, 1'b0, 4'd1, 1'b0}) begin
      errors++; $display("FAIL single_ack: got st=%0d g0=%0b rd=%0d av=%0b, expected st=3 g0=0 rd=1 av=0",
                         state, grant0, rd_index, avail);
    end
    req0 = 1;
    tick();
    tick();
    tick();
    checks++;
    if ({state, grant0, grant1} !== {S_IDLE, 1'b0, 1'b0}) begin
      errors++; $display("FAIL empty_no_grant: got st=%0d g0=%0b g1=%0b, expected st=0 g=00", state, grant0, grant1);
    end
    req0 = 0;
  endtask

  task automatic test_round_robin();
    logic [2:0] order;
    order = 3'b010;
    do_reset();
    wr_index = 4'd3;
    req0 = 1; req1 = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({grant0, grant1} !== {~order[i], order[i]}) begin
        errors++; $display("FAIL rr_grant%0d: got g0=%0b g1=%0b, expected g1=%0b", i, grant0, grant1, order[i]);
      end
      pulse_ack(order[i]);
      checks++;
      if ({state, grant0, grant1, rd_index} !== {S_RELEASE, 2'b00, 4'(i + 1)}) begin
        errors++; $display("FAIL rr_release%0d: got st=%0d g=%0b%0b rd=%0d, expected st=3 g=00 rd=%0d",
                           i, state, grant0, grant1, rd_index, i + 1);
      end
      tick();
      checks++;
      if (state !== S_IDLE) begin
        errors++; $display("FAIL rr_idle%0d: got st=%0d, expected 0", i, state);
      end
    end
    tick();
    checks++;
    if ({state, grant0, grant1, rd_index, avail} !== {S_IDLE, 2'b00, 4'd3, 1'b0}) begin
      errors++; $display("FAIL rr_end: got st=%0d g=%0b%0b rd=%0d av=%0b, expected st=0 g=00 rd=3 av=0",
                         state, grant0, grant1, rd_index, avail);
    end
    req0 = 0; req1 = 0;
  endtask

  // Follows test_round_robin: rr pointer now favours requester 1, rd_index=3.
  task automatic test_hold_and_stray_ack();
    wr_index = 4'd4;
    req0 = 1;
    tick();
    checks++;
    if ({grant0, grant1} !== 2'b10) begin
      errors++; $display("FAIL lone_req_vs_rr: got g0=%0b g1=%0b, expected 1 0", grant0, grant1);
    end
    req0 = 0;
    pulse_ack(1);
    tick();
    checks++;
    if ({state, grant0, rd_index} !== {S_GRANT0, 1'b1, 4'd3}) begin
      errors++; $display("FAIL hold_stray_ack: got st=%0d g0=%0b rd=%0d, expected st=1 g0=1 rd=3",
                         state, grant0, rd_index);
    end
    wr_index = 4'd3;
    #1;
    checks++;
    if ({state, avail, rd_index} !== {S_GRANT0, 1'b0, 4'd3}) begin
      errors++; $display("FAIL wr_change_in_grant: got st=%0d av=%0b rd=%0d, expected st=1 av=0 rd=3",
                         state, avail, rd_index);
    end
    wr_index = 4'd4;
    pulse_ack(0);
    checks++;
    if ({state, rd_index, avail} !== {S_RELEASE, 4'd4, 1'b0}) begin
      errors++; $display("FAIL hold_release: got st=%0d rd=%0d av=%0b, expected st=3 rd=4 av=0",
                         state, rd_index, avail);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    wr_index = 4'd15;
    req0 = 1;
    for (int i = 0; i < 15; i++) begin
      tick();
      pulse_ack(0);
      tick();
    end
    checks++;
    if ({state, rd_index, avail} !== {S_IDLE, 4'd15, 1'b0}) begin
      errors++; $display("FAIL wrap_setup: got st=%0d rd=%0d av=%0b, expected st=0 rd=15 av=0", state, rd_index, avail);
    end
    wr_index = 4'd0;
    tick();
    checks++;
    if (grant0 !== 1'b1) begin
      errors++; $display("FAIL wrap_grant: got g0=%0b, expected 1", grant0);
    end
    req0 = 0;
    pulse_ack(0);
    checks++;
    if ({rd_index, avail} !== {4'd0, 1'b0}) begin
      errors++; $display("FAIL wrap_index: got rd=%0d av=%0b, expected rd=0 av=0", rd_index, avail);
    end
  endtask

  task automatic test_offset_mux();
    do_reset();
    wr_index = 4'd1;
    off0 = 10'd9; off1 = 10'd5;
    req1 = 1;
    #1;
    checks++;
    if (off_mux !== 10'd9) begin
      errors++; $display("FAIL mux_idle: got %0d, expected 9", off_mux);
    end
    tick();
    req1 = 0;
    pulse_ack(0);
    checks++;
    if ({state, grant1, rd_index, off_mux} !== {S_GRANT1, 1'b1, 4'd0, 10'd5}) begin
      errors++; $display("FAIL mux_grant1_stray_ack0: got st=%0d g1=%0b rd=%0d off=%0d, expected st=2 g1=1 rd=0 off=5",
                         state, grant1, rd_index, off_mux);
    end
    off1 = 10'd7;
    #1;
    checks++;
    if (off_mux !== 10'd7) begin
      errors++; $display("FAIL mux_zero_latency: got %0d, expected 7", off_mux);
    end
    tick();
    pulse_ack(1);
    checks++;
    if ({state, rd_index, off_mux} !== {S_RELEASE, 4'd1, 10'd9}) begin
      errors++; $display("FAIL mux_release: got st=%0d rd=%0d off=%0d, expected st=3 rd=1 off=9", state, rd_index, off_mux);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    wr_index = 4'd5;
    req0 = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      pulse_ack(0);
      tick();
    end
    tick();
    checks++;
    if ({grant0, rd_index} !== {1'b1, 4'd2}) begin
      errors++; $display("FAIL midrst_setup: got g0=%0b rd=%0d, expected g0=1 rd=2", grant0, rd_index);
    end
    #2;
    rst = 1;
    #1;
    checks++;
    if ({state, grant0, grant1, rd_index} !== {S_IDLE, 2'b00, 4'd0}) begin
      errors++; $display("FAIL midrst_async: got st=%0d g=%0b%0b rd=%0d, expected st=0 g=00 rd=0",
                         state, grant0, grant1, rd_index);
    end
    #1;
    rst = 0;
    req1 = 1;
    tick();
    checks++;
    if ({grant0, grant1} !== 2'b10) begin
      errors++; $display("FAIL midrst_resume: got g0=%0b g1=%0b, expected 1 0", grant0, grant1);
    end
    req0 = 0; req1 = 0;
  endtask

`ifdef C2F_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    wr_index = 4'd1;
    req0 = 1;
    tick();
    req0 = 0;
    for (int k = 1; k < 16; k++) begin
      tick();
      checks++;
      if ({grant0, timeout} !== 2'b10) begin
        errors++; $display("FAIL wd_hold%0d: got g0=%0b to=%0b, expected 1 0", k, grant0, timeout);
      end
    end
    tick();
    checks++;
    if ({timeout, grant0, rd_index, state} !== {1'b1, 1'b0, 4'd1, S_RELEASE}) begin
      errors++; $display("FAIL wd_expire: got to=%0b g0=%0b rd=%0d st=%0d, expected to=1 g0=0 rd=1 st=3",
                         timeout, grant0, rd_index, state);
    end
    tick();
    checks++;
    if (timeout !== 1'b0) begin
      errors++; $display("FAIL wd_pulse_width: got to=%0b, expected 0", timeout);
    end
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_single_grant();
    test_round_robin();
    test_hold_and_stray_ack();
    test_wrap();
    test_offset_mux();
    test_reset_mid_grant();
`ifdef C2F_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
